// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle controller: opcode/funct fields,
// ALU operation codes, state encoding, datapath select encodings and instruction classes.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Must stay identical to the ALU's own operation decode.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_OR  = 4'd2,
        ALU_LUI = 4'd3,
        ALU_SLL = 4'd4
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [1:0] RD_RT   = 2'b00;
    localparam logic [1:0] RD_RD   = 2'b01;
    localparam logic [1:0] RD_RA   = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] PCS_INC = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;
    localparam logic [1:0] PCS_RS  = 2'b11;

    typedef struct packed {
        logic rtype_alu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic jr;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: IR contents to one-hot class plus the
// ALU operation, extension mode and B-operand select used during EXEC.
module mc_decode
    import mc_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t cls,
    output logic [3:0]   alu_op,
    output logic         ext_op,
    output logic         alu_src_b
);

    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    always_comb begin
        cls       = '0;
        alu_op    = ALU_ADD;
        ext_op    = 1'b0;
        alu_src_b = 1'b0;
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADDU: begin cls.rtype_alu = 1'b1; alu_op = ALU_ADD; end
                    FN_SUBU: begin cls.rtype_alu = 1'b1; alu_op = ALU_SUB; end
                    FN_SLL:  begin cls.rtype_alu = 1'b1; alu_op = ALU_SLL; end
                    FN_JR:   cls.jr = 1'b1;
                    default: cls.illegal = 1'b1;
                endcase
            end
            OP_ORI: begin
                cls.ori   = 1'b1;
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            OP_LUI: begin
                cls.lui   = 1'b1;
                alu_op    = ALU_LUI;
                alu_src_b = 1'b1;
            end
            OP_LW: begin
                cls.lw    = 1'b1;
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
            end
            OP_SW: begin
                cls.sw    = 1'b1;
                alu_src_b = 1'b1;
                ext_op    = 1'b1;
            end
            OP_BEQ: begin
                cls.beq = 1'b1;
                alu_op  = ALU_SUB;
            end
            OP_J:    cls.j   = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: state register plus per-state Moore output decode.
// Optional MC_CTRL_MEM_WAIT_EN stretches MEM until Mem_Ready is seen.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        Mem_Ready,
    output logic        PC_En,
    output logic        IR_En,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic [3:0]  ALUOp,
    output logic        ALUSrcB,
    output logic        ExtOp,
    output logic [1:0]  RegDst,
    output logic [1:0]  MemToReg,
    output logic [1:0]  PCSrc,
    output logic        Instr_Done,
    output logic        Illegal,
    output logic [2:0]  State
);

    state_t       state_q, state_d;
    instr_class_t cls;
    logic [3:0]   dec_alu_op;
    logic         dec_ext_op;
    logic         dec_alu_src_b;
    logic         mem_go;
    logic         unused_ok;

    mc_decode u_decode (
        .instr     (Instr),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .ext_op    (dec_ext_op),
        .alu_src_b (dec_alu_src_b)
    );

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go    = Mem_Ready;
    assign unused_ok = cls.ori ^ cls.lui;
`else
    assign mem_go    = 1'b1;
    assign unused_ok = cls.ori ^ cls.lui ^ Mem_Ready;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = ST_FETCH;
        PC_En      = 1'b0;
        IR_En      = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = ALU_ADD;
        ALUSrcB    = 1'b0;
        ExtOp      = 1'b0;
        RegDst     = RD_RT;
        MemToReg   = M2R_ALU;
        PCSrc      = PCS_INC;
        Instr_Done = 1'b0;
        Illegal    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                IR_En   = 1'b1;
                PC_En   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls.j || cls.jal) begin
                    PC_En      = 1'b1;
                    PCSrc      = PCS_JMP;
                    Instr_Done = 1'b1;
                    // PC already holds PC+4 from FETCH, which is the link value.
                    if (cls.jal) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemToReg = M2R_PC;
                    end
                end else if (cls.jr) begin
                    PC_En      = 1'b1;
                    PCSrc      = PCS_RS;
                    Instr_Done = 1'b1;
                end else if (cls.illegal) begin
                    Illegal    = 1'b1;
                    Instr_Done = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ALUOp   = dec_alu_op;
                ALUSrcB = dec_alu_src_b;
                ExtOp   = dec_ext_op;
                if (cls.beq) begin
                    PC_En      = Zero;
                    PCSrc      = PCS_BR;
                    Instr_Done = 1'b1;
                end else if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (cls.sw) begin
                    MemWrite   = 1'b1;
                    Instr_Done = mem_go;
                    state_d    = mem_go ? ST_FETCH : ST_MEM;
                end else begin
                    state_d    = mem_go ? ST_WB : ST_MEM;
                end
            end
            ST_WB: begin
                RegWrite   = 1'b1;
                Instr_Done = 1'b1;
                RegDst     = cls.rtype_alu ? RD_RD : RD_RT;
                MemToReg   = cls.lw ? M2R_MEM : M2R_ALU;
            end
            default: state_d = ST_FETCH;
        endcase
        // Reset silences every strobe and select, even though FETCH is already forced.
        if (reset) begin
            PC_En      = 1'b0;
            IR_En      = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            ALUOp      = ALU_ADD;
            ALUSrcB    = 1'b0;
            ExtOp      = 1'b0;
            RegDst     = RD_RT;
            MemToReg   = M2R_ALU;
            PCSrc      = PCS_INC;
            Instr_Done = 1'b0;
            Illegal    = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instructions plus random ones,
// compared cycle by cycle against a phase-list reference model.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        Mem_Ready;
    logic        PC_En, IR_En, RegWrite, MemWrite;
    logic [3:0]  ALUOp;
    logic        ALUSrcB, ExtOp;
    logic [1:0]  RegDst, MemToReg, PCSrc;
    logic        Instr_Done, Illegal;
    logic [2:0]  State;

    int checks = 0;
    int errors = 0;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
    localparam int LW_STALL_CYC = 8;
`else
    localparam bit WAIT_EN = 1'b0;
    localparam int LW_STALL_CYC = 5;
`endif

    localparam int C_ADDU = 0, C_SUBU = 1, C_SLL = 2, C_JR = 3, C_ORI = 4, C_LUI = 5;
    localparam int C_LW = 6, C_SW = 7, C_BEQ = 8, C_J = 9, C_JAL = 10, C_ILL = 11;
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4;

    mc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .Zero       (Zero),
        .Mem_Ready  (Mem_Ready),
        .PC_En      (PC_En),
        .IR_En      (IR_En),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .ALUSrcB    (ALUSrcB),
        .ExtOp      (ExtOp),
        .RegDst     (RegDst),
        .MemToReg   (MemToReg),
        .PCSrc      (PCSrc),
        .Instr_Done (Instr_Done),
        .Illegal    (Illegal),
        .State      (State)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'd0) begin
            case (fn)
                6'b100001: return C_ADDU;
                6'b100011: return C_SUBU;
                6'b000000: return C_SLL;
                6'b001000: return C_JR;
                default:   return C_ILL;
            endcase
        end
        case (op)
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    // Packed view of every output: {pc,ir,rw,mw,aluop,srcb,ext,regdst,m2r,pcsrc,done,ill,state}
    function automatic logic [31:0] pack(input logic pc, ir, rw, mw, input logic [3:0] op,
                                         input logic sb, ex, input logic [1:0] rd, m2r, pcs,
                                         input logic dn, il, input logic [2:0] st);
        return {11'b0, pc, ir, rw, mw, op, sb, ex, rd, m2r, pcs, dn, il, st};
    endfunction

    function automatic logic [31:0] dut_vec();
        return pack(PC_En, IR_En, RegWrite, MemWrite, ALUOp, ALUSrcB, ExtOp,
                    RegDst, MemToReg, PCSrc, Instr_Done, Illegal, State);
    endfunction

    function automatic logic [31:0] exp_vec(input int c, input int p, input logic z, input logic rdy);
        logic pc, ir, rw, mw, sb, ex, dn, il;
        logic [3:0] op;
        logic [1:0] rd, m2r, pcs;
        {pc, ir, rw, mw, sb, ex, dn, il} = '0;
        op = 4'd0; rd = 2'd0; m2r = 2'd0; pcs = 2'd0;
        case (p)
            P_F: begin ir = 1; pc = 1; end
            P_D: begin
                if (c == C_J || c == C_JAL) begin pc = 1; pcs = 2'd2; dn = 1; end
                if (c == C_JAL) begin rw = 1; rd = 2'd2; m2r = 2'd2; end
                if (c == C_JR) begin pc = 1; pcs = 2'd3; dn = 1; end
                if (c == C_ILL) begin il = 1; dn = 1; end
            end
            P_E: begin
                case (c)
                    C_ADDU: op = 4'd0;
                    C_SUBU: op = 4'd1;
                    C_SLL:  op = 4'd4;
                    C_ORI:  begin op = 4'd2; sb = 1; end
                    C_LUI:  begin op = 4'd3; sb = 1; end
                    C_LW, C_SW: begin op = 4'd0; sb = 1; ex = 1; end
                    C_BEQ:  begin op = 4'd1; pc = z; pcs = 2'd1; dn = 1; end
                    default: ;
                endcase
            end
            P_M: if (c == C_SW) begin mw = 1; dn = WAIT_EN ? rdy : 1'b1; end
            P_W: begin
                rw = 1; dn = 1;
                rd  = (c == C_ADDU || c == C_SUBU || c == C_SLL) ? 2'd1 : 2'd0;
                m2r = (c == C_LW) ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        return pack(pc, ir, rw, mw, op, sb, ex, rd, m2r, pcs, dn, il, p[2:0]);
    endfunction

    // Starts just after a rising edge with the DUT in FETCH; ends the same way.
    // zmode: 0/1 force Zero, 2 random. rdy_lo: MEM cycles with Mem_Ready low, -1 random.
    task automatic run_instr(input logic [31:0] ins, input int zmode, input int rdy_lo,
                             output int dut_cycles, output int model_cycles);
        int c;
        int ph[$];
        int idx;
        int mem_n;
        bit seen;
        c = classify(ins);
        ph.push_back(P_F);
        ph.push_back(P_D);
        if (c != C_J && c != C_JAL && c != C_JR && c != C_ILL) begin
            ph.push_back(P_E);
            if (c == C_LW || c == C_SW) ph.push_back(P_M);
            if (c != C_BEQ && c != C_SW) ph.push_back(P_W);
        end
        idx = 0; mem_n = 0; seen = 0;
        dut_cycles = 0; model_cycles = 0;
        Instr = ins;
        while (idx < ph.size()) begin
            if (model_cycles >= 60) begin
                check($sformatf("timeout i%08h", ins), model_cycles, 0);
                break;
            end
            Zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
            if (ph[idx] == P_M && rdy_lo >= 0) Mem_Ready = (mem_n >= rdy_lo);
            else                               Mem_Ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check($sformatf("i%08h p%0d", ins, ph[idx]), dut_vec(),
                  exp_vec(c, ph[idx], Zero, Mem_Ready));
            model_cycles++;
            if (!seen && Instr_Done) begin seen = 1; dut_cycles = model_cycles; end
            if (ph[idx] == P_M) mem_n++;
            if (!(ph[idx] == P_M && WAIT_EN && !Mem_Ready)) idx++;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] gen_rand();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  begin w[31:26] = 6'd0; w[5:0] = 6'b100001; end
            1:  begin w[31:26] = 6'd0; w[5:0] = 6'b100011; end
            2:  begin w[31:26] = 6'd0; w[5:0] = 6'b000000; end
            3:  begin w[31:26] = 6'd0; w[5:0] = 6'b001000; end
            4:  w[31:26] = 6'b001101;
            5:  w[31:26] = 6'b001111;
            6:  w[31:26] = 6'b100011;
            7:  w[31:26] = 6'b101011;
            8:  w[31:26] = 6'b000100;
            9:  w[31:26] = 6'b000010;
            10: w[31:26] = 6'b000011;
            default: begin
                for (int k = 0; k < 100 && classify(w) != C_ILL; k++) w = $urandom;
            end
        endcase
        return w;
    endfunction

    initial begin
        int n, m;
        reset = 1'b1; Instr = 32'h0; Zero = 1'b0; Mem_Ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset idle", dut_vec(), 32'h0);
        Instr = 32'h8C220004; Zero = 1'b1; Mem_Ready = 1'b1;
        #1;
        check("reset lw", dut_vec(), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(32'h3C011234, 2, -1, n, m); check("lui cycles", n, 4);
        run_instr(32'h00221821, 2, -1, n, m); check("addu cycles", n, 4);
        run_instr(32'h8C220004, 2, 3, n, m);  check("lw stall cycles", n, LW_STALL_CYC);
        run_instr(32'h8C220004, 2, 0, n, m);  check("lw cycles", n, 5);
        run_instr(32'h10220003, 1, -1, n, m); check("beq taken cycles", n, 3);
        run_instr(32'h10220003, 0, -1, n, m); check("beq not taken cycles", n, 3);
        run_instr(32'h0C000010, 2, -1, n, m); check("jal cycles", n, 2);
        run_instr(32'hFC000000, 2, -1, n, m); check("illegal cycles", n, 2);
        run_instr(32'h00000000, 2, -1, n, m); check("nop cycles", n, 4);
        run_instr(32'h03E00008, 2, -1, n, m); check("jr cycles", n, 2);

        // Reset asserted while sw sits in MEM must kill MemWrite at once.
        Instr = 32'hAC220008; Zero = 1'b0; Mem_Ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("sw mem state", {31'b0, MemWrite}, 32'h1);
        reset = 1'b1;
        #1;
        check("reset mid sw", dut_vec(), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        run_instr(32'hAC220008, 2, 0, n, m); check("sw cycles", n, 4);

        repeat (200) begin
            run_instr(gen_rand(), 2, -1, n, m);
            check("rand cycles", n, m);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit that sequences the shared 32-bit ALU, register file, instruction register and data memory through FETCH/DECODE/EXEC/MEM/WB states. It classifies the instruction held in the IR and drives per-state enables, mux selects and the 4-bit ALU operation code. It sits beside the datapath top level and is the only source of `ALUOp` and of every architectural write strobe.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Instr`  in  32  IR contents; valid from DECODE onward.
- `Zero`  in  1  ALU zero flag.
- `Mem_Ready`  in  1  data-memory ready; only used under `MC_CTRL_MEM_WAIT_EN`.
- `PC_En`  out  1  PC load.
- `IR_En`  out  1  IR load.
- `RegWrite`  out  1  register file write.
- `MemWrite`  out  1  data memory write.
- `ALUOp`  out  4  ADD=0, SUB=1, OR=2, LUI=3, SLL=4.
- `ALUSrcB`  out  1  0=rt data, 1=extended immediate.
- `ExtOp`  out  1  0=zero-extend, 1=sign-extend.
- `RegDst`  out  2  00=rt, 01=rd, 10=$31.
- `MemToReg`  out  2  00=ALU result register, 01=memory data register, 10=PC.
- `PCSrc`  out  2  00=PC+4, 01=PC+(sext(imm)<<2), 10={PC[31:28],idx,00}, 11=rs.
- `Instr_Done`  out  1  high in the final state of each instruction.
- `Illegal`  out  1  high in DECODE for an unrecognised instruction.
- `State`  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Other codes go to FETCH on the next edge.
- Classes (opcode/funct):
  - R: 000000 with addu 100001, subu 100011, sll 000000, jr 001000.
  - I: ori 001101, lui 001111, lw 100011, sw 101011, beq 000100.
  - J: j 000010, jal 000011.
  - Everything else is illegal. `nop` decodes as sll.
- FETCH: `IR_En`=1, `PC_En`=1, `PCSrc`=00. Always goes to DECODE.
- DECODE:
  - j: `PC_En`=1, `PCSrc`=10, Done. Next state FETCH.
  - jal: as j, plus `RegWrite`=1, `RegDst`=10, `MemToReg`=10. PC is already PC+4, so the link value is correct. Done, next FETCH.
  - jr: `PC_En`=1, `PCSrc`=11, Done, next FETCH.
  - illegal: `Illegal`=1, Done, next FETCH, no writes.
  - All other instructions go to EXEC.
- EXEC `ALUOp`/`ALUSrcB`/`ExtOp` settings:
  - addu: ADD, 0.
  - subu: SUB, 0.
  - sll: SLL, 0.
  - ori: OR, 1, zero-extend.
  - lui: LUI, 1.
  - lw and sw: ADD, 1, sign-extend.
  - beq: SUB, 0. `PC_En`=`Zero`, `PCSrc`=01, Done, next FETCH.
  - lw and sw go to MEM. The rest go to WB.
- MEM:
  - sw: `MemWrite`=1, Done, next FETCH.
  - lw: next WB.
- WB: `RegWrite`=1, Done, next FETCH.
  - `RegDst`: 01 for R-type, 00 for ori/lui/lw.
  - `MemToReg`: 01 for lw, otherwise 00.
- Outputs are Moore-style, decoded combinationally from `State` and `Instr`. `PC_En` in beq EXEC is the only `Zero`-dependent output.
- Every output not listed for a state is 0.

## Timing
- Cycles per instruction:
  - j, jal, jr, illegal: 2.
  - beq: 3.
  - addu, subu, sll, ori, lui, sw: 4.
  - lw: 5.
- While `reset`=1:
  - `State`=FETCH.
  - All enables and strobes (`PC_En`, `IR_En`, `RegWrite`, `MemWrite`, `Instr_Done`, `Illegal`) are 0.
  - Selects are 0.
- On reset deassertion, the first rising edge is a FETCH edge.
- Reset asserted mid-instruction: `State` goes to FETCH immediately (asynchronous). No partial write strobe survives.
- beq with `Zero`=0: PC holds its already-incremented value.

## Configuration
- `MC_CTRL_MEM_WAIT_EN` defined:
  - MEM holds while `Mem_Ready`=0.
  - sw keeps `MemWrite`=1 throughout the hold. `Instr_Done` and the transition occur only in the cycle where `Mem_Ready`=1.
  - lw leaves MEM only when `Mem_Ready`=1.
- Undefined: `Mem_Ready` is ignored and MEM always lasts exactly one cycle.

## Structure
- Shared package `mc_pkg` holds:
  - opcode/funct constants;
  - ALUOp codes (ADD..SLL, identical to the ALU);
  - state encoding;
  - `RegDst`, `MemToReg` and `PCSrc` select encodings.
- One natural sub-module, `mc_decode`: combinational `Instr` → class one-hot (rtype_alu, ori, lui, lw, sw, beq, j, jal, jr, illegal) plus ALUOp/ExtOp/ALUSrcB.
- `mc_ctrl` holds the state register and per-state output logic.

## Test plan
- Reset, then release; `Instr`=0x3C011234 (lui $1): states 0,1,2,4,0. WB shows `RegWrite`=1, `RegDst`=00, and EXEC shows `ALUOp`=3.
- `Instr`=0x00221821 (addu): EXEC `ALUOp`=0, `ALUSrcB`=0; WB `RegDst`=01; `Instr_Done` only in WB; 4 cycles.
- `Instr`=0x8C220004 (lw): 5 cycles, EXEC `ExtOp`=1, WB `MemToReg`=01. Under `MC_CTRL_MEM_WAIT_EN` with `Mem_Ready` low for 3 cycles: MEM lasts 4 cycles.
- `Instr`=0x10220003 (beq): with `Zero`=1, EXEC `PC_En`=1, `PCSrc`=01; with `Zero`=0, `PC_En`=0. 3 cycles.
- `Instr`=0x0C000010 (jal): DECODE `PC_En`=1, `PCSrc`=10, `RegWrite`=1, `RegDst`=10, `MemToReg`=10. Next state FETCH.
- `Instr`=0xFC000000: DECODE `Illegal`=1 with no writes. Separately, assert `reset` during sw MEM: `MemWrite` drops immediately and `State`=0.
